// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: walks regfile addresses 0..NUM_REGS-1 and streams
// header, one byte per register and an XOR checksum over a valid/ready source.
module regfile_dump_reader #(
  parameter int                NUM_REGS = 8,
  parameter int                ADDR_W   = 3,
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] HEADER   = 8'hA5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_done
);

  // state  | meaning
  // S_IDLE | waiting for start
  // S_HDR  | header byte offered
  // S_READ | one cycle, capture rd_data for r_index
  // S_SEND | register byte offered
  // S_CSUM | checksum byte offered
  // S_DONE | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_READ, S_SEND, S_CSUM, S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t              r_state,    w_state_nxt;
  logic [ADDR_W-1:0]   r_index,    w_index_nxt;
  logic [ADDR_W-1:0]   r_rd_addr,  w_rd_addr_nxt;
  logic [DATA_W-1:0]   r_checksum, w_checksum_nxt;
  logic [DATA_W-1:0]   r_tx_data,  w_tx_data_nxt;
  logic                r_tx_valid, w_tx_valid_nxt;
  logic                r_busy,     w_busy_nxt;
  logic                w_hs;

  assign w_hs = r_tx_valid & i_tx_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_index    <= '0;
      r_rd_addr  <= '0;
      r_checksum <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_index    <= w_index_nxt;
      r_rd_addr  <= w_rd_addr_nxt;
      r_checksum <= w_checksum_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_index_nxt    = r_index;
    w_rd_addr_nxt  = r_rd_addr;
    w_checksum_nxt = r_checksum;
    w_tx_data_nxt  = r_tx_data;
    w_tx_valid_nxt = r_tx_valid;
    w_busy_nxt     = r_busy;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt    = S_HDR;
          w_tx_data_nxt  = HEADER;
          w_tx_valid_nxt = 1'b1;
          w_busy_nxt     = 1'b1;
          w_index_nxt    = '0;
          w_checksum_nxt = '0;
        end
      end
      S_HDR: begin
        if (w_hs) begin
          w_state_nxt    = S_READ;
          w_tx_valid_nxt = 1'b0;
          w_rd_addr_nxt  = r_index;
        end
      end
      S_READ: begin
        w_state_nxt    = S_SEND;
        w_tx_data_nxt  = i_rd_data;
        w_checksum_nxt = r_checksum ^ i_rd_data;
        w_tx_valid_nxt = 1'b1;
      end
      S_SEND: begin
        if (w_hs) begin
          // last register goes to the checksum instead of wrapping to address 0
          if (r_index == LAST_IDX) begin
            w_state_nxt    = S_CSUM;
            w_tx_data_nxt  = r_checksum;
            w_tx_valid_nxt = 1'b1;
          end else begin
            w_state_nxt    = S_READ;
            w_index_nxt    = r_index + 1'b1;
            w_rd_addr_nxt  = r_index + 1'b1;
            w_tx_valid_nxt = 1'b0;
          end
        end
      end
      S_CSUM: begin
        if (w_hs) begin
          w_state_nxt    = S_DONE;
          w_tx_valid_nxt = 1'b0;
        end
      end
      S_DONE: begin
        w_state_nxt   = S_IDLE;
        w_busy_nxt    = 1'b0;
        w_rd_addr_nxt = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_busy     = r_busy;
  assign o_rd_addr  = r_rd_addr;
  assign o_tx_data  = r_tx_data;
  assign o_tx_valid = r_tx_valid;
  assign o_done     = (r_state == S_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader with a behavioural regfile and a
// byte monitor on the output stream.
module tb_regfile_dump_reader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       busy;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       done;

  logic [7:0] regs [8];
  assign rd_data = regs[rd_addr];

  regfile_dump_reader dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .o_busy     (busy),
    .o_rd_addr  (rd_addr),
    .i_rd_data  (rd_data),
    .o_tx_data  (tx_data),
    .o_tx_valid (tx_valid),
    .i_tx_ready (tx_ready),
    .o_done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc_cnt = 0;
  int         n_done = 0;
  bit         rdy_pat = 0;
  logic [7:0] q_bytes [$];
  int         done_cyc [$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  logic [7:0] exp_a [10] = '{8'hA5, 8'h00, 8'h11, 8'h22, 8'h33,
                             8'h44, 8'h55, 8'h66, 8'h7F, 8'h08};
  logic [7:0] exp_b [10] = '{8'hA5, 8'h00, 8'h11, 8'h22, 8'h9C,
                             8'h44, 8'h55, 8'h66, 8'h7F, 8'hA7};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sampled mid-cycle: record accepted bytes and check stalled bytes hold.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", {31'd0, tx_valid}, 32'd1);
        chk("stall_data", {24'd0, tx_data}, {24'd0, prev_data});
      end
      if (tx_valid && tx_ready) q_bytes.push_back(tx_data);
      if (done) begin
        n_done++;
        done_cyc.push_back(cyc_cnt);
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_cnt++;
    if (rdy_pat) tx_ready = (cyc_cnt % 3 == 0);
  endtask

  task automatic wait_done(input string tag, input int bound);
    int n = 0;
    while (!done && n < bound) begin
      cyc();
      n++;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp [10]);
    chk({tag, "_len"}, q_bytes.size(), 32'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < q_bytes.size()) chk(tag, {24'd0, q_bytes[i]}, {24'd0, exp[i]});
    end
  endtask

  initial begin
    int n;
    regs = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h7F};
    rst_n    = 1'b0;
    start    = 1'b0;
    tx_ready = 1'b1;
    #12;
    chk("rst_busy",  {31'd0, busy},     32'd0);
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_done",  {31'd0, done},     32'd0);
    chk("rst_addr",  {29'd0, rd_addr},  32'd0);
    chk("rst_data",  {24'd0, tx_data},  32'd0);
    rst_n = 1'b1;
    cyc(); cyc();

    // 1: plain frame, ready held high; done in cycle 19 counting start cycle as 0
    q_bytes.delete();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_hdr_valid", {31'd0, tx_valid}, 32'd1);
    chk("t1_hdr_data", {24'd0, tx_data}, 32'hA5);
    n = 1;
    while (!done && n < 100) begin
      cyc();
      n++;
    end
    chk("t1_done_cycle", n, 32'd19);
    chk("t1_busy_in_done", {31'd0, busy}, 32'd1);
    cyc();
    chk("t1_done_pulse", {31'd0, done}, 32'd0);
    chk("t1_busy_idle", {31'd0, busy}, 32'd0);
    cyc();
    check_frame("t1_byte", exp_a);

    // 2: ready asserted one cycle in three
    q_bytes.delete();
    rdy_pat = 1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_done("t2_done", 200);
    cyc(); cyc();
    rdy_pat = 0;
    tx_ready = 1'b1;
    check_frame("t2_byte", exp_a);

    // 3: start held 40 cycles -> two back-to-back frames 20 cycles apart
    q_bytes.delete();
    done_cyc.delete();
    n_done = 0;
    start = 1'b1;
    for (int i = 0; i < 40; i++) cyc();
    start = 1'b0;
    for (int i = 0; i < 30; i++) cyc();
    chk("t3_bytes", q_bytes.size(), 32'd20);
    chk("t3_ndone", n_done, 32'd2);
    if (done_cyc.size() == 2) chk("t3_gap", done_cyc[1] - done_cyc[0], 32'd20);
    if (q_bytes.size() == 20) begin
      chk("t3_hdr2", {24'd0, q_bytes[10]}, 32'hA5);
      chk("t3_csum2", {24'd0, q_bytes[19]}, 32'h08);
    end

    // 5: reg 3 rewritten while reg 1 is on the stream
    q_bytes.delete();
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc(); cyc();
    chk("t5_addr_r1", {29'd0, rd_addr}, 32'd1);
    regs[3] = 8'h9C;
    wait_done("t5_done", 100);
    cyc(); cyc();
    check_frame("t5_byte", exp_b);
    regs[3] = 8'h33;

    // 6: 50-cycle stall in SEND on register 0
    q_bytes.delete();
    n_done = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    tx_ready = 1'b0;
    cyc();
    for (int i = 0; i < 50; i++) begin
      cyc();
      chk("t6_valid", {31'd0, tx_valid}, 32'd1);
      chk("t6_addr",  {29'd0, rd_addr},  32'd0);
      chk("t6_busy",  {31'd0, busy},     32'd1);
      chk("t6_done",  {31'd0, done},     32'd0);
    end
    chk("t6_stall_data", {24'd0, tx_data}, 32'h00);
    tx_ready = 1'b1;
    wait_done("t6_done_end", 100);
    cyc(); cyc();
    check_frame("t6_byte", exp_a);

    // 4: async reset while stalled mid-frame after the fourth byte
    q_bytes.delete();
    start = 1'b1;
    cyc();
    start = 1'b0;
    n = 0;
    while (q_bytes.size() < 4 && n < 50) begin
      cyc();
      n++;
    end
    chk("t4_four_bytes", q_bytes.size(), 32'd4);
    tx_ready = 1'b0;
    cyc(); cyc();
    chk("t4_pre_valid", {31'd0, tx_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("t4_rst_busy",  {31'd0, busy},     32'd0);
    chk("t4_rst_done",  {31'd0, done},     32'd0);
    chk("t4_rst_addr",  {29'd0, rd_addr},  32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    tx_ready = 1'b1;
    q_bytes.delete();
    for (int i = 0; i < 10; i++) cyc();
    chk("t4_no_bytes", q_bytes.size(), 32'd0);
    chk("t4_idle_valid", {31'd0, tx_valid}, 32'd0);
    chk("t4_idle_busy",  {31'd0, busy},     32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
